// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, opcode, funct, ALUOp and mux-select codes for the multicycle control FSM
package cpu_ctrl_pkg;

    // State codes (5-bit, exported on the State debug port)
    localparam logic [4:0] ST_RST      = 5'd0;
    localparam logic [4:0] ST_F_ADDR   = 5'd1;
    localparam logic [4:0] ST_F_WAIT   = 5'd2;
    localparam logic [4:0] ST_F_IR     = 5'd3;
    localparam logic [4:0] ST_DECODE   = 5'd4;
    localparam logic [4:0] ST_EXEC_R   = 5'd5;
    localparam logic [4:0] ST_WB_R     = 5'd6;
    localparam logic [4:0] ST_EXEC_I   = 5'd7;
    localparam logic [4:0] ST_WB_I     = 5'd8;
    localparam logic [4:0] ST_MEM_ADDR = 5'd9;
    localparam logic [4:0] ST_LW_RD    = 5'd10;
    localparam logic [4:0] ST_LW_WAIT  = 5'd11;
    localparam logic [4:0] ST_LW_WB    = 5'd12;
    localparam logic [4:0] ST_SW_WR    = 5'd13;
    localparam logic [4:0] ST_BRANCH   = 5'd14;
    localparam logic [4:0] ST_JUMP     = 5'd15;
    localparam logic [4:0] ST_EXC_EPC  = 5'd16;
    localparam logic [4:0] ST_EXC_JMP  = 5'd17;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU function codes
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC = 2'd0;
    localparam logic [1:0] SRCA_A  = 2'd1;

    // ALU operand B select
    localparam logic [2:0] SRCB_B       = 3'd0;
    localparam logic [2:0] SRCB_FOUR    = 3'd1;
    localparam logic [2:0] SRCB_IMM     = 3'd2;
    localparam logic [2:0] SRCB_IMM_SH2 = 3'd3;

    // Next-PC source select
    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_EXC    = 3'd3;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational R-type Funct to ALUOp decode with valid and overflow-trap flags
module alu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid,
    output logic       ovf_trap
);

    // Map function code to ALU operation; ovf_trap marks the signed ops that trap on overflow
    always_comb begin
        alu_op   = ALU_NOP;
        valid    = 1'b1;
        ovf_trap = 1'b0;
        case (funct)
            FN_ADD: begin
                alu_op   = ALU_ADD;
                ovf_trap = 1'b1;
            end
            FN_SUB: begin
                alu_op   = ALU_SUB;
                ovf_trap = 1'b1;
            end
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle CPU main control FSM (Moore outputs, Zero-gated branch PC write)
module main_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ABWrite,
    output logic       ALUOutWrite,
    output logic       EPCWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [2:0] PCSource,
    output logic [4:0] State
);

    logic [4:0] state_q;
    logic [4:0] state_d;
    logic [2:0] r_alu_op;
    logic       r_valid;
    logic       r_ovf_trap;

    alu_op_decode u_alu_op_decode (
        .funct    (Funct),
        .alu_op   (r_alu_op),
        .valid    (r_valid),
        .ovf_trap (r_ovf_trap)
    );

    // Next-state selection; Opcode/Funct come from the IR and are stable across an instruction
    always_comb begin
        state_d = ST_RST;
        case (state_q)
            ST_RST:      state_d = ST_F_ADDR;
            ST_F_ADDR:   state_d = ST_F_WAIT;
            ST_F_WAIT:   state_d = ST_F_IR;
            ST_F_IR:     state_d = ST_DECODE;
            ST_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_EXC_EPC;
                endcase
            end
            ST_EXEC_R: begin
                if (!r_valid || (r_ovf_trap && Overflow)) state_d = ST_EXC_EPC;
                else                                      state_d = ST_WB_R;
            end
            ST_EXEC_I:   state_d = Overflow ? ST_EXC_EPC : ST_WB_I;
            ST_MEM_ADDR: state_d = (Opcode == OP_SW) ? ST_SW_WR : ST_LW_RD;
            ST_LW_RD:    state_d = ST_LW_WAIT;
            ST_LW_WAIT:  state_d = ST_LW_WB;
            ST_EXC_EPC:  state_d = ST_EXC_JMP;
            ST_WB_R, ST_WB_I, ST_LW_WB, ST_SW_WR,
            ST_BRANCH, ST_JUMP, ST_EXC_JMP:
                         state_d = ST_F_ADDR;
            default:     state_d = ST_RST;
        endcase
    end

    // Output decode from the state register; everything not named for a state stays 0
    always_comb begin
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ABWrite     = 1'b0;
        ALUOutWrite = 1'b0;
        EPCWrite    = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_NOP;
        PCSource    = PCSRC_ALU;
        case (state_q)
            ST_F_IR: begin
                IRWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALU_ADD;
                PCWrite = 1'b1;
            end
            ST_DECODE: begin
                ABWrite     = 1'b1;
                ALUOutWrite = 1'b1;
                ALUSrcB     = SRCB_IMM_SH2;
                ALUOp       = ALU_ADD;
            end
            ST_EXEC_R: begin
                ALUSrcA     = SRCA_A;
                ALUOutWrite = 1'b1;
                ALUOp       = r_alu_op;
            end
            ST_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ALUSrcA     = SRCA_A;
                ALUSrcB     = SRCB_IMM;
                ALUOp       = ALU_ADD;
                ALUOutWrite = 1'b1;
            end
            ST_WB_I:    RegWrite = 1'b1;
            ST_LW_RD, ST_LW_WAIT:
                        IorD = 1'b1;
            ST_LW_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            ST_SW_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA  = SRCA_A;
                ALUOp    = ALU_SUB;
                PCSource = PCSRC_ALUOUT;
                PCWrite  = Zero;
            end
            ST_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCWrite  = 1'b1;
            end
            ST_EXC_EPC: begin
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALU_SUB;
                EPCWrite = 1'b1;
            end
            ST_EXC_JMP: begin
                PCSource = PCSRC_EXC;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = state_q;

    // State register with synchronous active-low reset that overrides any in-flight instruction
    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= ST_RST;
        else        state_q <= state_d;
    end

endmodule
